// File: rtl/cache_and_ram_clever.sv
// Direct-mapped write-through / write-allocate cache in front of a word RAM.
// Ports: clk, reset (sync, high), address[31:0], data[31:0], mode (1=wr), out[31:0].

module cache_and_ram_clever #(
    parameter int CACHE_AW    = 12,
    parameter int RAM_AW      = 16,
    parameter int RAM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        mode,
    output logic [31:0] out
);

    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [31:0]       ram_wdata;
    logic [RAM_AW-1:0] ram_raddr;
    logic [31:0]       ram_rdata;

    cache_and_ram_clever_cache #(
        .CACHE_AW    (CACHE_AW),
        .RAM_AW      (RAM_AW),
        .RAM_LATENCY (RAM_LATENCY)
    ) cache (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .data      (data),
        .mode      (mode),
        .out       (out),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    cache_and_ram_clever_ram #(
        .RAM_AW (RAM_AW)
    ) ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// Backing word RAM: one synchronous write port, one asynchronous read port.
// Ports: clk, we, waddr, wdata, raddr, rdata.
module cache_and_ram_clever_ram #(
    parameter int RAM_AW = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [RAM_AW-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] ram [0:(1<<RAM_AW)-1];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
    end

    assign rdata = ram[raddr];

endmodule

// Cache controller: line storage plus IDLE/FETCH/FILL miss FSM.
// Ports: request port (address, data, mode, out) and RAM port (ram_*).
module cache_and_ram_clever_cache #(
    parameter int CACHE_AW    = 12,
    parameter int RAM_AW      = 16,
    parameter int RAM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic [31:0]       data,
    input  logic              mode,
    output logic [31:0]       out,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [31:0]       ram_wdata,
    output logic [RAM_AW-1:0] ram_raddr,
    input  logic [31:0]       ram_rdata
);

    localparam int LINES = 1 << CACHE_AW;
    localparam int TAG_W = RAM_AW - CACHE_AW;
    localparam int CW    = $clog2(RAM_LATENCY) + 1;
    localparam logic [CW-1:0] LAST = CW'(RAM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0]      cache       [0:LINES-1];
    logic [TAG_W-1:0] tag_array   [0:LINES-1];
    logic [LINES-1:0] valid_array;

    logic [CACHE_AW-1:0] index;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic                response_ram;
    logic                prev_response;
    logic                missrate;
    logic [31:0]         prev_address;
    logic [31:0]         fill_data;
    logic [CW-1:0]       cnt;

    logic                line_we;
    logic [CACHE_AW-1:0] line_idx;
    logic [TAG_W-1:0]    line_tag;
    logic [31:0]         line_data;

    assign index = address[CACHE_AW-1:0];
    assign tag   = address[RAM_AW-1:CACHE_AW];
    assign hit   = valid_array[index] && (tag_array[index] == tag);

    // Write-through: RAM sees every write in the same edge as the cache.
    assign ram_we    = (state == IDLE) && mode;
    assign ram_waddr = address[RAM_AW-1:0];
    assign ram_wdata = data;
    assign ram_raddr = prev_address[RAM_AW-1:0];

    // A line is written either by a write request or by a miss refill.
    always_comb begin
        line_we   = 1'b0;
        line_idx  = index;
        line_tag  = tag;
        line_data = data;
        if (state == IDLE && mode) begin
            line_we = 1'b1;
        end else if (state == FILL) begin
            line_we   = 1'b1;
            line_idx  = prev_address[CACHE_AW-1:0];
            line_tag  = prev_address[RAM_AW-1:CACHE_AW];
            line_data = fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (!mode && !hit) next_state = FETCH;
            FETCH:   if (cnt == LAST)   next_state = FILL;
            FILL:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Line storage is not cleared; valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (!reset && line_we) begin
            cache[line_idx]     <= line_data;
            tag_array[line_idx] <= line_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out           <= '0;
            valid_array   <= '0;
            missrate      <= 1'b0;
            response_ram  <= 1'b0;
            prev_response <= 1'b0;
            prev_address  <= '0;
            fill_data     <= '0;
            cnt           <= '0;
        end else begin
            prev_response <= response_ram;
            response_ram  <= 1'b0;
            if (line_we) valid_array[line_idx] <= 1'b1;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (mode) begin
                        out          <= data;
                        prev_address <= address;
                        missrate     <= 1'b0;
                    end else if (hit) begin
                        out      <= cache[index];
                        missrate <= 1'b0;
                    end else begin
                        missrate     <= 1'b1;
                        prev_address <= address;
                    end
                end
                FETCH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        response_ram <= 1'b1;
                        fill_data    <= ram_rdata;
                    end
                end
                FILL: begin
                    out <= fill_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_and_ram_clever.sv
// Scoreboard bench for cache_and_ram_clever.
// Drives held requests, predicts out/missrate from a reference model.

module tb_cache_and_ram_clever;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data;
    logic        mode;
    logic [31:0] out;

    int checks;
    int errors;

    logic [31:0] mem_m [int];
    logic [3:0]  tag_m [int];
    bit          val_m [int];

    logic [31:0] sb_q   [$];
    logic [31:0] miss_q [$];

    cache_and_ram_clever #(
        .CACHE_AW    (12),
        .RAM_AW      (16),
        .RAM_LATENCY (LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .data    (data),
        .mode    (mode),
        .out     (out)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        val_m.delete();
        reset = 1'b0;
    endtask

    // Predict, push to scoreboard, hold request, pop and compare.
    task automatic req(input string name, input logic [31:0] a,
                       input logic [31:0] d, input logic m, input int hold);
        int idx;
        int ra;
        bit was_hit;
        logic [31:0] exp;
        logic [31:0] expmiss;
        idx = int'(a[11:0]);
        ra  = int'(a[15:0]);
        was_hit = val_m.exists(idx) && val_m[idx] && (tag_m[idx] == a[15:12]);
        if (m) begin
            mem_m[ra] = d;
            exp = d;
            expmiss = 32'd0;
        end else begin
            exp = mem_m.exists(ra) ? mem_m[ra] : 32'hDEAD_BEEF;
            expmiss = (was_hit || hold > LAT + 2) ? 32'd0 : 32'd1;
        end
        val_m[idx] = 1'b1;
        tag_m[idx] = a[15:12];
        sb_q.push_back(exp);
        miss_q.push_back(expmiss);
        address = a;
        data    = m ? d : $urandom;
        mode    = m;
        repeat (hold) @(posedge clk);
        #1;
        check({name, "_out"}, out, sb_q.pop_front());
        check({name, "_miss"}, 32'(dut.cache.missrate), miss_q.pop_front());
    endtask

    initial begin
        int k;
        logic [31:0] a;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        address = '0;
        data    = '0;
        mode    = 1'b0;
        do_reset();
        check("rst_out", out, 32'd0);
        check("rst_miss", 32'(dut.cache.missrate), 32'd0);
        check("rst_resp", 32'(dut.cache.response_ram), 32'd0);
        check("rst_paddr", dut.cache.prev_address, 32'd0);

        // Basic writes then hits
        req("t1_w0", 32'd0, 32'd14528, 1'b1, 4);
        req("t1_w1", 32'd2816867292, 32'd526421, 1'b1, 4);
        req("t1_r0", 32'd0, 32'd0, 1'b0, 4);
        req("t1_r1", 32'd2816867292, 32'd0, 1'b0, 4);

        // Overwrites
        req("t2_w", 32'd1001425, 32'd25369366, 1'b1, 4);
        req("t2_r", 32'd1001425, 32'd0, 1'b0, 4);
        req("t2_ow1", 32'd2816867292, 32'd14528, 1'b1, 4);
        req("t2_ow2", 32'd1001425, 32'd14528, 1'b1, 4);
        req("t2_r1", 32'd2816867292, 32'd0, 1'b0, 4);
        req("t2_r2", 32'd1001425, 32'd0, 1'b0, 4);
        check("t2_paddr", dut.cache.prev_address, 32'd1001425);
        check("t2_ram", dut.ram.ram[16'(32'd1001425)], 32'd14528);

        // Miss timing after reset
        do_reset();
        address = 32'd2816867292;
        mode    = 1'b0;
        @(posedge clk); #1;
        check("t3_miss1", 32'(dut.cache.missrate), 32'd1);
        check("t3_resp1", 32'(dut.cache.response_ram), 32'd0);
        @(posedge clk); #1;
        check("t3_resp2", 32'(dut.cache.response_ram), 32'd0);
        @(posedge clk); #1;
        check("t3_resp3", 32'(dut.cache.response_ram), 32'd1);
        @(posedge clk); #1;
        check("t3_resp4", 32'(dut.cache.response_ram), 32'd0);
        check("t3_prevr", 32'(dut.cache.prev_response), 32'd1);
        check("t3_out", out, 32'd14528);
        check("t3_valid", 32'(dut.cache.valid_array[3036]), 32'd1);
        val_m[3036] = 1'b1;
        tag_m[3036] = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        check("t3_hitmiss", 32'(dut.cache.missrate), 32'd0);
        req("t3_rehit", 32'd2816867292, 32'd0, 1'b0, 4);

        // Tag conflict on one index
        req("t4_wf", 32'h0000_FBDC, 32'd55, 1'b1, 4);
        req("t4_w0", 32'h0000_0BDC, 32'd7, 1'b1, 4);
        req("t4_rf", 32'h0000_FBDC, 32'd0, 1'b0, 4);
        req("t4_r0", 32'h0000_0BDC, 32'd0, 1'b0, 4);

        // Reset during FETCH aborts the fill
        address = 32'h0000_0777;
        mode    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        val_m.delete();
        check("t5_out", out, 32'd0);
        check("t5_valid", 32'(dut.cache.valid_array[12'h777]), 32'd0);
        check("t5_state", 32'(dut.cache.state), 32'd0);
        check("t5_miss", 32'(dut.cache.missrate), 32'd0);
        check("t5_resp", 32'(dut.cache.response_ram), 32'd0);

        // Aliasing above RAM_AW
        req("t6_w", 32'h0001_0005, 32'd99, 1'b1, 4);
        req("t6_r", 32'h0000_0005, 32'd0, 1'b0, 4);

        // Random mix over four conflicting tags
        for (int i = 0; i < 4; i++) begin
            a = (32'(i) << 12) | 32'd7;
            req("rnd_w", a, $urandom, 1'b1, 4);
        end
        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, 3));
            a = (32'(k) << 12) | 32'd7;
            if ($urandom_range(0, 2) == 0)
                req("rnd_w", a, $urandom, 1'b1, 4);
            else
                req("rnd_r", a, 32'd0, 1'b0, 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
